// File: rtl/sprite_row_renderer.sv
// Scan-line renderer for one horizontal row of identical, scaled, optionally mirrored sprites.
// Bitmap contents come from the BITMAP parameter: row r occupies bits [r*W +: W], and bit c is column c.
module sprite_row_renderer #(
    parameter int SPRITE_WIDTH  = 16,
    parameter int SPRITE_HEIGHT = 8,
    parameter int SPRITE_SCALE  = 2,
    parameter int NUM_SPRITES   = 8,
    parameter int SPACING       = 8,
    parameter int NUM_FRAMES    = 2,
    parameter logic [NUM_FRAMES*SPRITE_HEIGHT*SPRITE_WIDTH-1:0] BITMAP = {
        16'h4422, 16'h2db4, 16'h1248, 16'h3ffc, 16'h366c, 16'h1ff8, 16'h0ff0, 16'h0660,
        16'h2814, 16'h1668, 16'h0990, 16'h3ffc, 16'h366c, 16'h1ff8, 16'h0ff0, 16'h0660},
    parameter int RES_H = 640,
    parameter int RES_V = 480,
    localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1,
    localparam int IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
    localparam int XW = $clog2(RES_H),
    localparam int YW = $clog2(RES_V)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [9:0]             spr_x,
    input  logic [9:0]             spr_y,
    input  logic [NUM_SPRITES-1:0] alive,
    input  logic [FW-1:0]          frame_sel,
    input  logic                   mirror,
    input  logic [XW-1:0]          pixel_x,
    input  logic [YW-1:0]          pixel_y,
    output logic                   spr_draw,
    output logic [IW-1:0]          spr_idx,
    output logic                   busy,
    output logic                   done
);
    localparam int CW   = (SPRITE_SCALE > 1) ? $clog2(SPRITE_SCALE) : 1;
    localparam int XCW  = (SPRITE_WIDTH > 1) ? $clog2(SPRITE_WIDTH) : 1;
    localparam int YCW  = (SPRITE_HEIGHT > 1) ? $clog2(SPRITE_HEIGHT) : 1;
    localparam int GW   = (SPACING > 1) ? $clog2(SPACING) : 1;
    localparam int ROWS = NUM_FRAMES * SPRITE_HEIGHT;
    localparam int RAW  = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [2:0] {
        IDLE, START, AWAIT_ROW, AWAIT_POS, DRAW, GAP, NEXT_LINE
    } state_t;

    // Handshake: a start pulse is taken only while busy is low (IDLE); busy rises the
    // next cycle and stays high until the frame ends, when done pulses for one cycle.
    state_t                 state, state_n;
    logic [9:0]             x0_q, x0_n, y0_q, y0_n;
    logic [NUM_SPRITES-1:0] alive_q, alive_n;
    logic [FW-1:0]          frame_q, frame_n;
    logic                   mirror_q, mirror_n;
    logic [XCW-1:0]         x_q, x_n;
    logic [YCW-1:0]         y_q, y_n;
    logic [CW-1:0]          cnt_x_q, cnt_x_n, cnt_y_q, cnt_y_n;
    logic [GW-1:0]          cnt_gap_q, cnt_gap_n;
    logic [IW-1:0]          idx_q, idx_n;
    logic                   done_q, done_n;

    logic [SPRITE_WIDTH-1:0] rom [ROWS];
    logic [RAW-1:0]          row_addr;
    logic [XCW-1:0]          col;
    logic                    pix;

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            rom[r] = BITMAP[r*SPRITE_WIDTH +: SPRITE_WIDTH];
        end
        row_addr = RAW'(frame_q) * RAW'(SPRITE_HEIGHT) + RAW'(y_q);
        col      = mirror_q ? XCW'(SPRITE_WIDTH - 1) - x_q : x_q;
        pix      = rom[row_addr][col];
    end

    always_comb begin
        state_n   = state;
        x0_n      = x0_q;
        y0_n      = y0_q;
        alive_n   = alive_q;
        frame_n   = frame_q;
        mirror_n  = mirror_q;
        x_n       = x_q;
        y_n       = y_q;
        cnt_x_n   = cnt_x_q;
        cnt_y_n   = cnt_y_q;
        cnt_gap_n = cnt_gap_q;
        idx_n     = idx_q;
        done_n    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n  = START;
                    x0_n     = spr_x;
                    y0_n     = spr_y;
                    alive_n  = alive;
                    frame_n  = frame_sel;
                    mirror_n = mirror;
                end
            end
            START: begin
                state_n = AWAIT_ROW;
                y_n     = '0;
                cnt_y_n = '0;
            end
            AWAIT_ROW: begin
                if (32'(pixel_y) == 32'(y0_q)) state_n = AWAIT_POS;
            end
            AWAIT_POS: begin
                if (32'(pixel_x) == 32'(x0_q)) begin
                    state_n   = DRAW;
                    x_n       = '0;
                    cnt_x_n   = '0;
                    idx_n     = '0;
                    cnt_gap_n = '0;
                end
            end
            DRAW: begin
                if (32'(cnt_x_q) == SPRITE_SCALE - 1) begin
                    cnt_x_n = '0;
                    if (32'(x_q) == SPRITE_WIDTH - 1) begin
                        x_n = '0;
                        if (32'(idx_q) < NUM_SPRITES - 1) begin
                            idx_n     = idx_q + 1'b1;
                            cnt_gap_n = '0;
                            state_n   = (SPACING == 0) ? DRAW : GAP;
                        end else if (32'(y_q) == SPRITE_HEIGHT - 1 &&
                                     32'(cnt_y_q) == SPRITE_SCALE - 1) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end else begin
                            state_n = NEXT_LINE;
                        end
                    end else begin
                        x_n = x_q + 1'b1;
                    end
                end else begin
                    cnt_x_n = cnt_x_q + 1'b1;
                end
            end
            GAP: begin
                if (32'(cnt_gap_q) == SPACING - 1) begin
                    state_n   = DRAW;
                    x_n       = '0;
                    cnt_x_n   = '0;
                    cnt_gap_n = '0;
                end else begin
                    cnt_gap_n = cnt_gap_q + 1'b1;
                end
            end
            NEXT_LINE: begin
                // pixel_x is already past x0, so AWAIT_POS matches on the next scan line
                state_n = AWAIT_POS;
                if (32'(cnt_y_q) == SPRITE_SCALE - 1) begin
                    cnt_y_n = '0;
                    y_n     = y_q + 1'b1;
                end else begin
                    cnt_y_n = cnt_y_q + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            x0_q      <= '0;
            y0_q      <= '0;
            alive_q   <= '0;
            frame_q   <= '0;
            mirror_q  <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            cnt_x_q   <= '0;
            cnt_y_q   <= '0;
            cnt_gap_q <= '0;
            idx_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_n;
            x0_q      <= x0_n;
            y0_q      <= y0_n;
            alive_q   <= alive_n;
            frame_q   <= frame_n;
            mirror_q  <= mirror_n;
            x_q       <= x_n;
            y_q       <= y_n;
            cnt_x_q   <= cnt_x_n;
            cnt_y_q   <= cnt_y_n;
            cnt_gap_q <= cnt_gap_n;
            idx_q     <= idx_n;
            done_q    <= done_n;
        end
    end

    assign spr_draw = (state == DRAW) && alive_q[idx_q] && pix;
    assign spr_idx  = spr_draw ? idx_q : '0;
    assign busy     = (state != IDLE);
    assign done     = done_q;
endmodule

// File: tb/tb_sprite_row_renderer.sv
// Bench for sprite_row_renderer: two instances (scale 1 and 2) on a small 64x16 raster,
// checked pixel by pixel against a geometric model, plus directed probe vectors.
module tb_sprite_row_renderer;
    localparam int W = 4, H = 2, N = 2, SP = 2, NF = 2, RES_H = 64, RES_V = 16;
    localparam logic [NF*H*W-1:0] BM = 16'h81FF;

    typedef struct {
        int         x0;
        int         y0;
        logic [N-1:0] alive;
        logic       fsel;
        logic       mirror;
    } cfg_t;

    typedef struct {
        cfg_t cfg;
        int   px;
        int   py;
        bit   d1;
        int   i1;
        bit   d2;
        int   i2;
    } vec_t;

    logic         clk = 1'b0, rst = 1'b0, start = 1'b0, mirror = 1'b0;
    logic [9:0]   spr_x = '0, spr_y = '0;
    logic [N-1:0] alive = '0;
    logic [0:0]   frame_sel = '0;
    logic [5:0]   pixel_x = '0;
    logic [3:0]   pixel_y = '0;
    logic         draw1, draw2, busy1, busy2, done1, done2;
    logic [0:0]   idx1, idx2;

    int checks = 0, errors = 0, cur_x = -1, cur_y = -1;
    logic [W-1:0] bm [NF*H];

    sprite_row_renderer #(.SPRITE_WIDTH(W), .SPRITE_HEIGHT(H), .SPRITE_SCALE(1), .NUM_SPRITES(N),
        .SPACING(SP), .NUM_FRAMES(NF), .BITMAP(BM), .RES_H(RES_H), .RES_V(RES_V)) dut1 (
        .clk(clk), .rst(rst), .start(start), .spr_x(spr_x), .spr_y(spr_y), .alive(alive),
        .frame_sel(frame_sel), .mirror(mirror), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .spr_draw(draw1), .spr_idx(idx1), .busy(busy1), .done(done1));

    sprite_row_renderer #(.SPRITE_WIDTH(W), .SPRITE_HEIGHT(H), .SPRITE_SCALE(2), .NUM_SPRITES(N),
        .SPACING(SP), .NUM_FRAMES(NF), .BITMAP(BM), .RES_H(RES_H), .RES_V(RES_V)) dut2 (
        .clk(clk), .rst(rst), .start(start), .spr_x(spr_x), .spr_y(spr_y), .alive(alive),
        .frame_sel(frame_sel), .mirror(mirror), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .spr_draw(draw2), .spr_idx(idx2), .busy(busy2), .done(done2));

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at x=%0d y=%0d: got %0d, expected %0d", name, cur_x, cur_y, act, exp);
        end
    endtask

    // Screen-space model: which sprite cell, if any, covers pixel (px,py).
    function automatic void model(input int s, input cfg_t c, input int px, input int py,
                                  output bit d, output int idx);
        int stride, rx, ry, i, off, col, row;
        stride = W * s + SP;
        rx = px - (c.x0 + 1);
        ry = py - c.y0;
        d = 1'b0;
        idx = 0;
        if (rx >= 0 && ry >= 0 && ry < H * s) begin
            i = rx / stride;
            off = rx % stride;
            if (i < N && off < W * s) begin
                col = off / s;
                row = ry / s;
                if (c.mirror) col = W - 1 - col;
                if (c.alive[i] && bm[int'(c.fsel) * H + row][col]) begin
                    d = 1'b1;
                    idx = i;
                end
            end
        end
    endfunction

    function automatic int lin_last(input int s, input cfg_t c);
        return (c.y0 + H * s - 1) * RES_H + c.x0 + N * (W * s + SP) - SP;
    endfunction

    task automatic run_frame(input cfg_t c, input bit chaos, input int restart_at, input int rst_at,
                             input int probe_x, input int probe_y,
                             output bit pd1, output int pi1, output bit pd2, output int pi2,
                             output int dc1, output int dc2);
        int  last1, last2, ei1, ei2;
        bit  aborted, ed1, ed2;
        last1 = lin_last(1, c);
        last2 = lin_last(2, c);
        aborted = 1'b0;
        dc1 = 0; dc2 = 0; pd1 = 1'b0; pd2 = 1'b0; pi1 = 0; pi2 = 0;
        for (int lin = 0; lin < RES_H * RES_V; lin++) begin
            cur_x = lin % RES_H;
            cur_y = lin / RES_H;
            pixel_x = 6'(cur_x);
            pixel_y = 4'(cur_y);
            if (lin == 0) begin
                start = 1'b1;
                spr_x = 10'(c.x0);
                spr_y = 10'(c.y0);
                alive = c.alive;
                frame_sel = c.fsel;
                mirror = c.mirror;
            end else begin
                start = 1'b0;
                if (lin == restart_at) begin
                    start = 1'b1;
                    spr_x = 10'(c.x0 + 7);
                end else if (chaos) begin
                    start = (lin <= last1) && ($urandom_range(0, 15) == 0);
                    spr_x = 10'($urandom_range(0, 1023));
                    spr_y = 10'($urandom_range(0, 1023));
                    alive = N'($urandom);
                    frame_sel = 1'($urandom);
                    mirror = 1'($urandom);
                end
            end
            if (lin == rst_at) begin
                rst = 1'b1;
                #1;
                aborted = 1'b1;
                check("rst_draw1", int'(draw1), 0);
                check("rst_busy1", int'(busy1), 0);
                check("rst_done1", int'(done1), 0);
                check("rst_draw2", int'(draw2), 0);
                check("rst_busy2", int'(busy2), 0);
                check("rst_done2", int'(done2), 0);
            end
            @(negedge clk);
            model(1, c, cur_x, cur_y, ed1, ei1);
            model(2, c, cur_x, cur_y, ed2, ei2);
            if (aborted) begin
                ed1 = 1'b0; ed2 = 1'b0; ei1 = 0; ei2 = 0;
            end
            check("draw1", int'(draw1), int'(ed1));
            check("idx1", int'(idx1), ei1);
            check("busy1", int'(busy1), int'(!aborted && lin >= 1 && lin <= last1));
            check("done1", int'(done1), int'(!aborted && lin == last1 + 1));
            check("draw2", int'(draw2), int'(ed2));
            check("idx2", int'(idx2), ei2);
            check("busy2", int'(busy2), int'(!aborted && lin >= 1 && lin <= last2));
            check("done2", int'(done2), int'(!aborted && lin == last2 + 1));
            if (done1) dc1++;
            if (done2) dc2++;
            if (cur_x == probe_x && cur_y == probe_y) begin
                pd1 = draw1; pi1 = int'(idx1); pd2 = draw2; pi2 = int'(idx2);
            end
            rst = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_vec(input vec_t v, input bit chaos, input int restart_at, input int rst_at,
                           input int exp_done);
        bit pd1, pd2;
        int pi1, pi2, dc1, dc2;
        run_frame(v.cfg, chaos, restart_at, rst_at, v.px, v.py, pd1, pi1, pd2, pi2, dc1, dc2);
        cur_x = v.px;
        cur_y = v.py;
        if (v.px >= 0) begin
            check("probe_draw1", int'(pd1), int'(v.d1));
            check("probe_idx1", pi1, v.i1);
            check("probe_draw2", int'(pd2), int'(v.d2));
            check("probe_idx2", pi2, v.i2);
        end
        check("done_count1", dc1, exp_done);
        check("done_count2", dc2, exp_done);
    endtask

    initial begin
        cfg_t c1, c;
        vec_t vecs[10];
        vec_t v;
        bm[0] = 4'b1111;
        bm[1] = 4'b1111;
        bm[2] = 4'b0001;
        bm[3] = 4'b1000;
        c1 = '{x0: 10, y0: 5, alive: 2'b11, fsel: 1'b0, mirror: 1'b0};
        vecs[0] = '{cfg: c1, px: 11, py: 5, d1: 1, i1: 0, d2: 1, i2: 0};
        vecs[1] = '{cfg: c1, px: 17, py: 6, d1: 1, i1: 1, d2: 1, i2: 0};
        vecs[2] = '{cfg: c1, px: 15, py: 5, d1: 0, i1: 0, d2: 1, i2: 0};
        vecs[3] = '{cfg: c1, px: 12, py: 7, d1: 0, i1: 0, d2: 1, i2: 0};
        c = c1; c.alive = 2'b01;
        vecs[4] = '{cfg: c, px: 18, py: 5, d1: 0, i1: 0, d2: 1, i2: 0};
        c = c1; c.fsel = 1'b1;
        vecs[5] = '{cfg: c, px: 11, py: 5, d1: 1, i1: 0, d2: 1, i2: 0};
        vecs[8] = '{cfg: c, px: 14, py: 6, d1: 1, i1: 0, d2: 0, i2: 0};
        c.mirror = 1'b1;
        vecs[6] = '{cfg: c, px: 11, py: 5, d1: 0, i1: 0, d2: 0, i2: 0};
        vecs[7] = '{cfg: c, px: 14, py: 5, d1: 1, i1: 0, d2: 0, i2: 0};
        c = c1; c.alive = 2'b10;
        vecs[9] = '{cfg: c, px: 11, py: 5, d1: 0, i1: 0, d2: 0, i2: 0};

        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_draw1", int'(draw1), 0);
        check("reset_idx1", int'(idx1), 0);
        check("reset_busy1", int'(busy1), 0);
        check("reset_done1", int'(done1), 0);
        check("reset_draw2", int'(draw2), 0);
        check("reset_idx2", int'(idx2), 0);
        check("reset_busy2", int'(busy2), 0);
        check("reset_done2", int'(done2), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], 1'b0, -1, -1, 1);

        // second start mid-DRAW with a moved spr_x must be ignored
        v = '{cfg: c1, px: 17, py: 5, d1: 1, i1: 1, d2: 1, i2: 0};
        run_vec(v, 1'b0, 5 * RES_H + 12, -1, 1);
        // a start after done takes the new position
        c = c1; c.x0 = 20; c.y0 = 3;
        v = '{cfg: c, px: 21, py: 3, d1: 1, i1: 0, d2: 1, i2: 0};
        run_vec(v, 1'b0, -1, -1, 1);
        // reset in the middle of DRAW, then a clean frame
        v = '{cfg: c1, px: 12, py: 6, d1: 0, i1: 0, d2: 0, i2: 0};
        run_vec(v, 1'b0, -1, 5 * RES_H + 13, 0);
        v = '{cfg: c1, px: 20, py: 6, d1: 1, i1: 1, d2: 0, i2: 0};
        run_vec(v, 1'b0, -1, -1, 1);

        for (int i = 0; i < 8; i++) begin
            c.x0 = $urandom_range(1, 40);
            c.y0 = $urandom_range(1, 12);
            c.alive = N'($urandom);
            c.fsel = 1'($urandom);
            c.mirror = 1'($urandom);
            v = '{cfg: c, px: -1, py: -1, d1: 0, i1: 0, d2: 0, i2: 0};
            run_vec(v, 1'b1, -1, -1, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
